// File: rtl/maxpool_seq_if.sv
// rtl/maxpool_seq_if.sv - stream handshake bundle between a feature source, the pool and its consumer
interface maxpool_seq_if #(
    parameter int DATA_W = 4,
    parameter int IDX_W  = 4
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic [IDX_W-1:0]  out_idx;
    logic              out_valid;
    logic              out_ready;

    // master: feature source plus result consumer; slave: the pooling block
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_idx, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_idx, out_valid
    );
endinterface

// File: rtl/maxpool_seq.sv
// rtl/maxpool_seq.sv - sequential max-pool with argmax over WIN-element windows
module maxpool_seq #(
    parameter int DATA_W = 4,
    parameter int WIN    = 4,
    parameter int IDX_W  = 4
) (
    input  logic                clk,
    input  logic                rst,
    maxpool_seq_if.slave        bus,
    output logic [15:0]         win_cnt
);

    typedef enum logic {
        ACC = 1'b0,
        OUT = 1'b1
    } state_e;

    localparam logic [IDX_W-1:0] LAST_POS = IDX_W'(WIN - 1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  pos_q, pos_d;
    logic [DATA_W-1:0] max_q, max_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [15:0]       win_cnt_q, win_cnt_d;
    logic              accept;
    logic              produce;

    assign accept  = bus.in_valid && (state_q == ACC);
    assign produce = bus.out_ready && (state_q == OUT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ACC;
            pos_q     <= '0;
            max_q     <= '0;
            idx_q     <= '0;
            win_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            max_q     <= max_d;
            idx_q     <= idx_d;
            win_cnt_q <= win_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        max_d     = max_q;
        idx_d     = idx_q;
        win_cnt_d = win_cnt_q;

        if (accept) begin
            // first element seeds the window; later ones replace only on a strictly larger value
            if (pos_q == '0) begin
                max_d = bus.in_data;
                idx_d = '0;
            end else if (bus.in_data > max_q) begin
                max_d = bus.in_data;
                idx_d = pos_q;
            end

            if (pos_q == LAST_POS) begin
                pos_d   = '0;
                state_d = OUT;
            end else begin
                pos_d = pos_q + IDX_W'(1);
            end
        end

        if (produce) begin
            state_d   = ACC;
            win_cnt_d = win_cnt_q + 16'd1;
        end
    end

    assign bus.in_ready  = (state_q == ACC);
    assign bus.out_valid = (state_q == OUT);
    assign bus.out_data  = max_q;
    assign bus.out_idx   = idx_q;
    assign win_cnt       = win_cnt_q;

endmodule

// File: tb/tb_maxpool_seq.sv
// tb/tb_maxpool_seq.sv - randomized and directed self-checking bench for maxpool_seq
module tb_maxpool_seq;

    localparam int DATA_W = 4;
    localparam int WIN    = 4;
    localparam int IDX_W  = 4;

    logic        clk;
    logic        rst;
    logic [15:0] win_cnt;

    maxpool_seq_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) bus ();

    maxpool_seq #(.DATA_W(DATA_W), .WIN(WIN), .IDX_W(IDX_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .win_cnt (win_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // reference model: accepted elements of the open window and the held result
    logic [DATA_W-1:0] m_win[$];
    bit                m_out;
    int                m_res_data;
    int                m_res_idx;
    int                m_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_win.delete();
        m_out      = 1'b0;
        m_res_data = 0;
        m_res_idx  = 0;
        m_cnt      = 0;
    endtask

    task automatic model_close_window();
        int best;
        best = 0;
        for (int i = 1; i < WIN; i++)
            if (m_win[i] > m_win[best]) best = i;
        m_res_data = int'(m_win[best]);
        m_res_idx  = best;
        m_win.delete();
        m_out = 1'b1;
    endtask

    task automatic check_outputs();
        check("in_ready", 32'(bus.in_ready), 32'(!m_out));
        check("out_valid", 32'(bus.out_valid), 32'(m_out));
        check("win_cnt", 32'(win_cnt), 32'(m_cnt & 16'hFFFF));
        if (m_out) begin
            check("out_data", 32'(bus.out_data), 32'(m_res_data));
            check("out_idx", 32'(bus.out_idx), 32'(m_res_idx));
        end
    endtask

    // called at a falling edge: check, drive, advance one rising edge, update model
    task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic r);
        bit was_out;
        check_outputs();
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = r;
        was_out = m_out;
        @(posedge clk);
        if (!was_out && v) begin
            m_win.push_back(d);
            if (m_win.size() == WIN) model_close_window();
        end
        if (was_out && r) begin
            m_out = 1'b0;
            m_cnt++;
        end
        @(negedge clk);
    endtask

    task automatic feed_elem(input logic [DATA_W-1:0] d, input logic r, input bit sparse);
        bit accepted;
        accepted = 1'b0;
        for (int t = 0; t < 40 && !accepted; t++) begin
            if (sparse && ($urandom_range(0, 1) == 1)) begin
                step(1'b0, DATA_W'($urandom), r);
            end else begin
                accepted = !m_out;
                step(1'b1, d, r);
            end
        end
        if (!accepted) check("feed_timeout", 32'd0, 32'd1);
    endtask

    task automatic feed_window(input logic [4*DATA_W-1:0] w, input logic r, input bit sparse);
        for (int i = 0; i < WIN; i++)
            feed_elem(w[(WIN-1-i)*DATA_W +: DATA_W], r, sparse);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_out_idx", 32'(bus.out_idx), 32'd0);
        check("rst_win_cnt", 32'(win_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        do_reset();

        // 3,9,2,7 back-to-back
        feed_window({4'h3, 4'h9, 4'h2, 4'h7}, 1'b1, 1'b0);
        check("basic_valid", 32'(bus.out_valid), 32'd1);
        check("basic_data", 32'(bus.out_data), 32'h9);
        check("basic_idx", 32'(bus.out_idx), 32'd1);
        step(1'b0, '0, 1'b1);
        check("basic_cnt", 32'(win_cnt), 32'd1);

        // ties keep the earliest position
        feed_window({4'h5, 4'h5, 4'h5, 4'h5}, 1'b1, 1'b0);
        check("tie5_idx", 32'(bus.out_idx), 32'd0);
        step(1'b0, '0, 1'b1);
        feed_window({4'h0, 4'h0, 4'h0, 4'h0}, 1'b1, 1'b0);
        check("tie0_data", 32'(bus.out_data), 32'd0);
        step(1'b0, '0, 1'b1);

        // backpressure, including inputs offered while the result is held
        feed_window({4'h1, 4'h2, 4'h3, 4'hF}, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 4'hE, 1'b0);
        check("bp_data", 32'(bus.out_data), 32'hF);
        check("bp_idx", 32'(bus.out_idx), 32'd3);
        step(1'b0, '0, 1'b1);

        // sparse input
        feed_window({4'h8, 4'h1, 4'hC, 4'h4}, 1'b1, 1'b1);
        check("sparse_data", 32'(bus.out_data), 32'hC);
        check("sparse_idx", 32'(bus.out_idx), 32'd2);
        step(1'b0, '0, 1'b1);

        // reset mid-window discards the partial window
        feed_elem(4'h6, 1'b1, 1'b0);
        feed_elem(4'hE, 1'b1, 1'b0);
        do_reset();
        feed_window({4'h2, 4'h3, 4'h1, 4'h0}, 1'b0, 1'b0);
        check("abort_data", 32'(bus.out_data), 32'h3);
        check("abort_idx", 32'(bus.out_idx), 32'd1);
        step(1'b0, '0, 1'b1);

        // reset while a result is held
        feed_window({4'h7, 4'h2, 4'h9, 4'h1}, 1'b0, 1'b0);
        do_reset();

        // max is not carried across windows
        feed_window({4'hA, 4'h1, 4'h1, 4'h1}, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1);
        feed_window({4'h1, 4'h1, 4'h1, 4'h2}, 1'b1, 1'b0);
        check("carry_data", 32'(bus.out_data), 32'h2);
        check("carry_idx", 32'(bus.out_idx), 32'd3);
        step(1'b0, '0, 1'b1);
        check("carry_cnt", 32'(win_cnt), 32'd2);

        // random traffic on both interfaces against the model
        for (int i = 0; i < 2000; i++)
            step(1'(($urandom_range(0, 3) != 0)), DATA_W'($urandom), 1'($urandom_range(0, 1)));
        check_outputs();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
